btn_pulse_gen: RTL and testbench
================================

Name: btn_pulse_gen

Overview:
- Upstream input conditioner for the push-button counter and 7-segment display stages.
- Synchronizes a raw mechanical button and debounces it with an FSM.
- Emits a single-cycle `btn_trig` pulse per accepted press, which the downstream BCD counter consumes as its increment enable.
- Also provides a debounced level and a release pulse for the piezo/feedback logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a press or release (20 ms at 50 MHz); legal range ≥2.
- REPEAT_DELAY, 25000000, cycles held after the accepted press before the first auto-repeat pulse (only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- btn  input  1  raw button, active-high, asynchronous to clk
- btn_trig  output  1  one-cycle pulse per accepted press (and per auto-repeat)
- btn_level  output  1  debounced button state
- btn_release  output  1  one-cycle pulse when a release is accepted

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk.
  - On reset, all outputs, both synchronizer flops and all counters are cleared to 0.
  - State goes to IDLE.
  - Reset mid-operation aborts any press in progress. No pulse is emitted during or on exit from reset.
- Synchronizer: 2-flop chain on btn, giving `btn_s`. All FSM decisions use `btn_s` only.
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1), saturating, never wraps.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: if btn_s=1, go to PRESS_WAIT with cnt=1. Otherwise stay.
  - PRESS_WAIT: if btn_s=0, go to IDLE with cnt=0 (glitch rejected, no output). If cnt==DEBOUNCE_CYCLES, go to HELD. Otherwise cnt++.
  - HELD: if btn_s=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: if btn_s=1, return to HELD with cnt=0 (bounce, no pulse). If cnt==DEBOUNCE_CYCLES, go to IDLE. Otherwise cnt++.
- Outputs on transitions:
  - PRESS_WAIT→HELD registers btn_trig=1 for exactly one cycle and sets btn_level=1.
  - RELEASE_WAIT→IDLE registers btn_release=1 for one cycle and clears btn_level=0.
- Latency: btn_trig is high on the edge DEBOUNCE_CYCLES+3 cycles after the first clk edge that samples btn=1, given btn stays high throughout.
- Release latency: the same count from the first low sample.
- One press yields exactly one btn_trig, regardless of hold length (without AUTO_REPEAT_EN).
- btn_trig and btn_release are never high in the same cycle.
- A level held constant across reset deassertion is treated as a new event: a button held through reset release produces one btn_trig after debounce.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - A repeat counter runs in HELD, starting from 0 at HELD entry.
  - At REPEAT_DELAY it pulses btn_trig for one cycle and reloads to 0.
  - Thereafter it pulses every REPEAT_PERIOD cycles while in HELD.
  - Leaving HELD (to RELEASE_WAIT) freezes the counter. Returning from RELEASE_WAIT to HELD resumes it without reset. Entry from PRESS_WAIT clears it.
  - The counter is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- Undefined: no repeat counter is synthesized, and REPEAT_* are unused.

Decomposition:
- Package `btn_pkg`:
  - state encoding localparams (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3)
  - default timing constants
- One sub-module: `sync_2ff` (1-bit 2-flop synchronizer with async active-low reset). It is reused by other input stages.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
1. btn held 1 for 20 cycles → single btn_trig pulse 7 cycles after first high sample; btn_level=1; no further pulses.
2. btn pulses 1 for 3 cycles then 0 → no btn_trig, btn_level stays 0, FSM back to IDLE.
3. After accepted press, btn low 2 cycles then high → no btn_release, btn_level stays 1; final long release → one btn_release, btn_level=0.
4. rst asserted low while in PRESS_WAIT with cnt=3 → all outputs 0 immediately; after release of rst with btn=0, no pulse.
5. AUTO_REPEAT_EN, btn held 30 cycles → btn_trig at press acceptance, again 10 cycles later, then every 3 cycles until release.
6. Reset released with btn already 1 → exactly one btn_trig after debounce latency.

Source files
------------

// File: rtl/btn_pulse_gen_pkg.sv
// ============================================================================
// btn_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the push-button input conditioner:
//   - btn_state_e : debounce FSM state encoding
//   - DEF_*       : default timing constants (50 MHz system clock)
//   - max_u       : helper used to size the optional auto-repeat counter
// ============================================================================
package btn_pkg;

    // Debounce FSM states. The encoding values are kept stable so that
    // anything probing the state register keeps decoding it the same way.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // 20 ms of stable samples at 50 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    // 500 ms hold before the first auto-repeat pulse.
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    // 100 ms between subsequent auto-repeat pulses.
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : btn_pkg

// File: rtl/btn_pulse_gen_sync_2ff.sv
// ============================================================================
// sync_2ff
// ----------------------------------------------------------------------------
// 1-bit two-flop synchronizer for an input that is asynchronous to clk.
// Both flops clear to 0 on reset, so a level present across reset release is
// seen downstream as a fresh 0->1 transition.
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-low reset
//   d   : asynchronous input
//   q   : synchronized output (two clk edges of latency)
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : sync_2ff

// File: rtl/btn_pulse_gen.sv
// ============================================================================
// btn_pulse_gen
// ----------------------------------------------------------------------------
// Input conditioner for a raw mechanical push-button. The button is
// synchronized (sync_2ff), debounced by a four-state FSM, and turned into:
//   - btn_trig    : one-cycle pulse per accepted press (increment enable for
//                   the downstream BCD counter)
//   - btn_level   : debounced button level
//   - btn_release : one-cycle pulse per accepted release
//
// Build option:
//   AUTO_REPEAT_EN - when defined, holding the button emits extra btn_trig
//                    pulses: first after REPEAT_DELAY cycles in HELD, then
//                    every REPEAT_PERIOD cycles. When undefined no repeat
//                    logic exists and REPEAT_* are unused.
//
// Ports:
//   clk         : system clock
//   rst         : asynchronous, active-low reset
//   btn         : raw button, active-high, asynchronous to clk
//   btn_trig    : press / auto-repeat pulse
//   btn_level   : debounced level
//   btn_release : release pulse
// ============================================================================
module btn_pulse_gen
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_trig,
    output logic btn_level,
    output logic btn_release
);

    localparam int unsigned          CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic btn_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    btn_state_e       state_q;
    btn_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             accept_d;   // PRESS_WAIT -> HELD this cycle
    logic             rel_d;      // RELEASE_WAIT -> IDLE this cycle

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        rel_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end

            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = HELD;
                    cnt_d    = '0;
                    accept_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end

            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Auto-repeat counter (optional)
    // ------------------------------------------------------------------
    logic rpt_d;   // repeat pulse decided this cycle

`ifdef AUTO_REPEAT_EN
    localparam int unsigned      RPT_MAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned      RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;
    logic             rpt_first_q;   // still waiting out REPEAT_DELAY
    logic             rpt_first_d;
    logic [RPT_W-1:0] rpt_limit;

    // The counter advances only while the FSM stays in HELD; it freezes in
    // RELEASE_WAIT so a bounce back to HELD resumes where it left off.
    // A limit of N-1 makes the pulse land N cycles after the previous one.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_d       = 1'b0;
        rpt_limit   = rpt_first_q ? RPT_W'(REPEAT_DELAY - 1)
                                  : RPT_W'(REPEAT_PERIOD - 1);

        if (accept_d) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (state_q == HELD && btn_s) begin
            if (rpt_cnt_q == rpt_limit) begin
                rpt_d       = 1'b1;
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`else
    logic unused_rpt_params;

    assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};

    always_comb begin
        rpt_d = 1'b0;
    end
`endif

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    // Transition strobes are captured in one register stage and the ports
    // are driven from a second, which places btn_trig/btn_release
    // DEBOUNCE_CYCLES+3 edges after the first edge that sees the new level.
    logic accept_q;
    logic rel_q;
    logic rpt_q;
    logic btn_trig_q;
    logic btn_trig_d;
    logic btn_level_q;
    logic btn_level_d;
    logic btn_release_q;
    logic btn_release_d;

    always_comb begin
        btn_trig_d    = accept_q | rpt_q;
        btn_release_d = rel_q;
        btn_level_d   = btn_level_q;
        if (accept_q) begin
            btn_level_d = 1'b1;
        end else if (rel_q) begin
            btn_level_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            accept_q      <= 1'b0;
            rel_q         <= 1'b0;
            rpt_q         <= 1'b0;
            btn_trig_q    <= 1'b0;
            btn_level_q   <= 1'b0;
            btn_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            accept_q      <= accept_d;
            rel_q         <= rel_d;
            rpt_q         <= rpt_d;
            btn_trig_q    <= btn_trig_d;
            btn_level_q   <= btn_level_d;
            btn_release_q <= btn_release_d;
        end
    end

    assign btn_trig    = btn_trig_q;
    assign btn_level   = btn_level_q;
    assign btn_release = btn_release_q;

endmodule : btn_pulse_gen

// File: tb/tb_btn_pulse_gen.sv
// ============================================================================
// tb_btn_pulse_gen
// ----------------------------------------------------------------------------
// Directed bench for btn_pulse_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Inputs change on the falling edge; outputs are checked on
// the falling edge. Step index i counts falling edges after btn changes, so
// the first rising edge sampling the new level is edge 0 and an output that
// rises on edge k is observed at i = k+1. Define AUTO_REPEAT_EN for both the
// RTL and this bench to exercise the repeat path.
// ============================================================================
module tb_btn_pulse_gen;

    logic clk;
    logic rst;
    logic btn;
    logic btn_trig;
    logic btn_level;
    logic btn_release;

    int errors;
    int checks;

    btn_pulse_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .btn_trig    (btn_trig),
        .btn_level   (btn_level),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic exp_trig,
                        input logic exp_level, input logic exp_rel);
        chk({tag, "/trig"},    btn_trig,    exp_trig);
        chk({tag, "/level"},   btn_level,   exp_level);
        chk({tag, "/release"}, btn_release, exp_rel);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        btn    = 1'b0;

        // Reset state
        repeat (3) tick();
        chk3("reset_hold", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        chk3("reset_exit", 1'b0, 1'b0, 1'b0);

`ifndef AUTO_REPEAT_EN
        // 1: held press -> one trig at i=8, level follows, no more pulses
        btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk3("t1_press", (i == 8), (i >= 8), 1'b0);
        end

        // 3: two-cycle release bounce is rejected
        btn = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk3("t3_bounce_lo", 1'b0, 1'b1, 1'b0);
        end
        btn = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk3("t3_bounce_hi", 1'b0, 1'b1, 1'b0);
        end
        // long release -> one release pulse at i=8
        btn = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk3("t3_release", 1'b0, (i < 8), (i == 8));
        end
`else
        // 5: auto-repeat: trig at 8, 18, then every 3 while held
        btn = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            chk3("t5_repeat",
                 (i == 8) || (i >= 18 && i <= 33 && ((i - 18) % 3) == 0),
                 (i >= 8 && i < 38),
                 (i == 38));
            if (i == 30) btn = 1'b0;
        end
`endif

        // 2: 3-cycle glitch is rejected
        btn = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk3("t2_glitch", 1'b0, 1'b0, 1'b0);
            if (i == 3) btn = 1'b0;
        end

        // 4: reset during PRESS_WAIT (cnt=3 after edge 4)
        btn = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        btn = 1'b0;
        #1;
        chk3("t4_in_reset", 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk3("t4_after_reset", 1'b0, 1'b0, 1'b0);
        end

        // Async reset clears a set level immediately
        btn = 1'b1;
        repeat (9) tick();
        chk("t4b_level_set", btn_level, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk3("t4b_async_clear", 1'b0, 1'b0, 1'b0);

        // 6: button held through reset release -> one trig after debounce
        repeat (2) tick();
        chk3("t6_in_reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk3("t6_held_thru_reset", (i == 8), (i >= 8), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_btn_pulse_gen
